// File: rtl/imuldiv_int_div_iterative_pkg.sv
// Shared definitions for the iterative 32-bit integer divider:
// function encodings, FSM states, iteration count and a small helper.
package imuldiv_int_div_iterative_pkg;

    localparam logic DIVFN_SIGNED   = 1'b0;
    localparam logic DIVFN_UNSIGNED = 1'b1;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_W-1:0] abs_if(
        input logic [DIV_W-1:0] v,
        input logic             en
    );
        return (en && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DIV_W-1:0] neg_if(
        input logic [DIV_W-1:0] v,
        input logic             en
    );
        return en ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/imuldiv_int_div_iterative_if.sv
// Request/response handshake bundle for the iterative divider.
interface imuldiv_int_div_iterative_if;

    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;

    logic [63:0] divresp_msg_result;
    logic        divresp_val;
    logic        divresp_rdy;

    modport master (
        output divreq_msg_fn,
        output divreq_msg_a,
        output divreq_msg_b,
        output divreq_val,
        input  divreq_rdy,
        input  divresp_msg_result,
        input  divresp_val,
        output divresp_rdy
    );

    modport slave (
        input  divreq_msg_fn,
        input  divreq_msg_a,
        input  divreq_msg_b,
        input  divreq_val,
        output divreq_rdy,
        output divresp_msg_result,
        output divresp_val,
        input  divresp_rdy
    );

endinterface

// File: rtl/imuldiv_int_div_iterative_dpath.sv
// Divider datapath: operand latches, 65-bit restoring shift/subtract
// register and the combinational sign / divide-by-zero fixup.
module imuldiv_int_div_iterative_dpath
    import imuldiv_int_div_iterative_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        done,
    input  logic        fn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic        fn_q;
    logic        quot_neg_q;
    logic        rem_neg_q;
    logic        zero_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [64:0] rq_q;

    logic        is_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [64:0] rq_step;

    logic        fix_signed;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] quot_out;
    logic [31:0] rem_out;

    assign is_signed = (fn == DIVFN_SIGNED);
    assign a_abs     = abs_if(a, is_signed);
    assign b_abs     = abs_if(b, is_signed);

    // Remainder never exceeds the divisor, so the top bit is always
    // clear before the shift and the 33-bit trial difference is exact.
    assign shifted = rq_q << 1;
    assign diff    = shifted[64:32] - {1'b0, b_q};

    always_comb begin
        rq_step = shifted;
        if (!diff[32]) begin
            rq_step = {diff, shifted[31:1], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fn_q       <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            zero_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rq_q       <= '0;
        end else if (load) begin
            fn_q       <= fn;
            quot_neg_q <= is_signed & (a[31] ^ b[31]);
            rem_neg_q  <= is_signed & a[31];
            zero_q     <= (b == '0);
            a_q        <= a;
            b_q        <= b_abs;
            rq_q       <= {33'd0, a_abs};
        end else if (step) begin
            rq_q       <= rq_step;
        end
    end

    assign fix_signed = (fn_q == DIVFN_SIGNED);
    assign quot_fix   = neg_if(rq_q[31:0], fix_signed & quot_neg_q);
    assign rem_fix    = neg_if(rq_q[63:32], fix_signed & rem_neg_q);

    // Divide by zero reports all-ones and the untouched dividend.
    assign quot_out = zero_q ? 32'hFFFF_FFFF : quot_fix;
    assign rem_out  = zero_q ? a_q : rem_fix;

    assign result = done ? {rem_out, quot_out} : 64'd0;

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-cycle restoring divider (signed/unsigned div+rem).
// Build option IMULDIV_DIV_ZERO_BYPASS_EN: divide-by-zero skips CALC.
module imuldiv_int_div_iterative
    import imuldiv_int_div_iterative_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    imuldiv_int_div_iterative_if.slave   div
);

    div_state_e         state_q;
    div_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               load;
    logic               step;
    logic               done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        load            = 1'b0;
        step            = 1'b0;
        done            = 1'b0;
        div.divreq_rdy  = 1'b0;
        div.divresp_val = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                div.divreq_rdy = 1'b1;
                if (div.divreq_val) begin
                    load    = 1'b1;
                    state_d = ST_CALC;
                    cnt_d   = CNT_W'(DIV_ITERS);
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
                    if (div.divreq_msg_b == '0) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            ST_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done            = 1'b1;
                div.divresp_val = 1'b1;
                if (div.divresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    imuldiv_int_div_iterative_dpath u_dpath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .done   (done),
        .fn     (div.divreq_msg_fn),
        .a      (div.divreq_msg_a),
        .b      (div.divreq_msg_b),
        .result (div.divresp_msg_result)
    );

endmodule

// File: doc/imuldiv_int_div_iterative.md
IMULDIV_INT_DIV_ITERATIVE -- requirements
Module: imuldiv_int_div_iterative

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and iteration count at 32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 divreq_msg_fn  input  1  0 = signed div/rem, 1 = unsigned div/rem.
REQ-005 divreq_msg_a  input  32  dividend.
REQ-006 divreq_msg_b  input  32  divisor.
REQ-007 divreq_val  input  1  request valid.
REQ-008 divreq_rdy  output  1  request ready.
REQ-009 divresp_msg_result  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 divresp_val  output  1  response valid.
REQ-011 divresp_rdy  input  1  response ready.

Function
REQ-012 A request SHALL be accepted on any clk edge where divreq_val and divreq_rdy are both 1 (fire); a response SHALL complete on any edge where divresp_val and divresp_rdy are both 1.
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; any unused encoding SHALL go to IDLE on the next edge.
REQ-014 IDLE: divreq_rdy=1, divresp_val=0; on fire, latch |a|, |b|, fn, quotient sign (a31^b31, signed only), remainder sign (a31, signed only) and a divide-by-zero flag (b==0); go to CALC with the iteration counter set to 32.
REQ-015 CALC: divreq_rdy=0, divresp_val=0; each cycle performs one restoring step on a 65-bit {rem,quot} register: shift left 1, trial-subtract the divisor from the upper half, and if non-negative keep the difference and set quot LSB to 1, else restore and set it to 0; decrement the counter; go to DONE after the 32nd step.
REQ-016 Latency: the fire edge is cycle 0; divresp_val SHALL first be 1 in cycle 33.
REQ-017 DONE: divresp_val=1, divreq_rdy=0; the result SHALL be held stable until response fire, then the block returns to IDLE; a new request is accepted no earlier than the cycle after response fire.
REQ-018 Signed fixup SHALL be combinational in DONE: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
REQ-019 Divide by zero (both fn) SHALL return quotient 0xFFFFFFFF and remainder equal to the original dividend, overriding the fixup.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return quotient 0x80000000, remainder 0.
REQ-021 Unsigned operation SHALL perform no sign conversion on operands or results.
REQ-022 Request inputs outside the fire edge SHALL be ignored; operand changes after fire SHALL not affect the result.

Reset
REQ-023 While reset=0: state=IDLE, counter=0, datapath registers and latched flags=0, divreq_rdy=1, divresp_val=0, divresp_msg_result=0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation with no response produced.

Configuration
REQ-025 With IMULDIV_DIV_ZERO_BYPASS_EN defined, a divide-by-zero request SHALL skip CALC, with divresp_val=1 in cycle 1 after fire; without it, divide-by-zero SHALL take the full 33-cycle latency. Result values SHALL be identical in both builds.

Structure
REQ-026 A shared imuldiv package SHALL hold the fn encodings (DIVFN_SIGNED=0, DIVFN_UNSIGNED=1), the FSM state encodings and the iteration count constant (32).
REQ-027 The datapath (operand registers, 65-bit shift/subtract register, fixup muxes) SHALL be one sub-module, imuldiv_int_div_iterative_dpath; the FSM and counter remain in the top.

Verification
REQ-028 Signed a=0xFFFFFFF9 (-7), b=2 -> result {0xFFFFFFFF, 0xFFFFFFFD}, divresp_val first high 33 cycles after fire.
REQ-029 Unsigned a=100, b=7 -> {0x00000002, 0x0000000E}; the same operands as signed -> same result.
REQ-030 Signed a=0xFFFFFFF9, b=0 -> {0xFFFFFFF9, 0xFFFFFFFF}; latency 33 without the macro, 1 with it.
REQ-031 Signed a=0x80000000, b=0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-032 Hold divresp_rdy=0 for 5 cycles in DONE -> divresp_val stays 1, result stable, divreq_rdy stays 0; the next request is accepted only after response fire.
REQ-033 Assert reset at cycle 10 of CALC -> divresp_val=0, divreq_rdy=1 immediately; a following request 20/3 unsigned returns {2, 6}.
